// File: rtl/vga_timing_gen.sv
// VGA timing generator: clock-enable pixel divider, H/V raster counters and
// registered sync/blank/strobe outputs aligned with the pixel coordinates.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CW       = 11
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          EN,
    output logic          pixel_tick,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          line_start,
    output logic          frame_start,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SS    = H_ACTIVE + H_FP;
    localparam int unsigned H_SE    = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int unsigned V_SS    = V_ACTIVE + V_FP;
    localparam int unsigned V_SE    = V_ACTIVE + V_FP + V_SYNC - 1;
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] r_div_cnt;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_video_on;
    logic          r_line_start;
    logic          r_frame_start;

    logic          w_div_last;
    logic          w_tick;
    logic          w_x_wrap;
    logic          w_y_wrap;
    logic [CW-1:0] w_x_next;
    logic [CW-1:0] w_y_next;
    logic          w_hs_next;
    logic          w_vs_next;
    logic          w_vo_next;

    // With CLK_DIV=1 the divider stays at 0, so w_div_last is constantly true.
    assign w_div_last = (r_div_cnt == DW'(CLK_DIV - 1));
    assign w_tick     = EN & w_div_last;
    assign w_x_wrap   = (r_x == CW'(H_TOTAL - 1));
    assign w_y_wrap   = (r_y == CW'(V_TOTAL - 1));

    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_tick) begin
            w_x_next = w_x_wrap ? '0 : r_x + CW'(1);
            if (w_x_wrap) begin
                w_y_next = w_y_wrap ? '0 : r_y + CW'(1);
            end
        end
    end

    // Decode from the next counts so the registered outputs line up with pixel_x/pixel_y.
    always_comb begin
        w_hs_next = ((w_x_next >= CW'(H_SS)) && (w_x_next <= CW'(H_SE))) ? HS_POL : ~HS_POL;
        w_vs_next = ((w_y_next >= CW'(V_SS)) && (w_y_next <= CW'(V_SE))) ? VS_POL : ~VS_POL;
        w_vo_next = (w_x_next < CW'(H_ACTIVE)) && (w_y_next < CW'(V_ACTIVE));
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_div_cnt     <= '0;
            r_x           <= CW'(H_TOTAL - 1);
            r_y           <= CW'(V_TOTAL - 1);
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_video_on    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (EN) begin
            r_div_cnt     <= w_div_last ? '0 : r_div_cnt + DW'(1);
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_hsync       <= w_hs_next;
            r_vsync       <= w_vs_next;
            r_video_on    <= w_vo_next;
            r_line_start  <= w_tick & w_x_wrap;
            r_frame_start <= w_tick & w_x_wrap & w_y_wrap;
        end
    end

    assign pixel_tick  = w_tick;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign pixel_x     = r_x;
    assign pixel_y     = r_y;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every cycle against
// a raster model derived from the count of enabled clock edges.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, hp, vp, div;
    } cfg_t;

    cfg_t cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 4};
    cfg_t cfg_b = '{8, 2, 3, 2, 4, 1, 2, 1, 1, 0, 3};
    cfg_t cfg_c = '{800, 40, 128, 88, 600, 1, 4, 23, 1, 1, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit run_chk  = 1'b1;

    logic rst_a = 1'b1, en_a = 1'b1;
    logic rst_b = 1'b1, en_b = 1'b1;
    logic rst_c = 1'b1, en_c = 1'b1;

    logic tick_a, hs_a, vs_a, vo_a, ls_a, fs_a;
    logic tick_b, hs_b, vs_b, vo_b, ls_b, fs_b;
    logic tick_c, hs_c, vs_c, vo_c, ls_c, fs_c;
    logic [10:0] x_a, y_a, x_c, y_c;
    logic [4:0]  x_b, y_b;

    vga_timing_gen dut_a (
        .CLK(clk), .RESET(rst_a), .EN(en_a), .pixel_tick(tick_a), .hsync(hs_a), .vsync(vs_a),
        .video_on(vo_a), .line_start(ls_a), .frame_start(fs_a), .pixel_x(x_a), .pixel_y(y_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(3), .CW(5)
    ) dut_b (
        .CLK(clk), .RESET(rst_b), .EN(en_b), .pixel_tick(tick_b), .hsync(hs_b), .vsync(vs_b),
        .video_on(vo_b), .line_start(ls_b), .frame_start(fs_b), .pixel_x(x_b), .pixel_y(y_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .CW(11)
    ) dut_c (
        .CLK(clk), .RESET(rst_c), .EN(en_c), .pixel_tick(tick_c), .hsync(hs_c), .vsync(vs_c),
        .video_on(vo_c), .line_start(ls_c), .frame_start(fs_c), .pixel_x(x_c), .pixel_y(y_c)
    );

    // Enabled clock edges seen by each DUT since its last reset.
    int e_a = 0, e_b = 0, e_c = 0;
    always @(posedge clk) begin
        e_a <= rst_a ? 0 : (en_a ? e_a + 1 : e_a);
        e_b <= rst_b ? 0 : (en_b ? e_b + 1 : e_b);
        e_c <= rst_c ? 0 : (en_c ? e_c + 1 : e_c);
    end

    task automatic check_val(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", tag, act, exp, $time);
        end
    endtask

    // Raster position is the (n-1)th pixel of the frame sequence after n pixel ticks.
    task automatic cmp_dut(input string tag, input cfg_t c, input int e_raw, input logic en,
                           input logic rst, input logic [5:0] flags, input int x, input int y);
        int e, ht, vt, n, p, ex, ey;
        bit last, ls, fs, tick, hs, vs, vo;
        e  = rst ? 0 : e_raw;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        n  = e / c.div;
        if (n == 0) begin
            ex = ht - 1;
            ey = vt - 1;
        end else begin
            p  = (n - 1) % (ht * vt);
            ex = p % ht;
            ey = p / ht;
        end
        last = (e >= 1) && (e % c.div == 0);
        ls   = last && (ex == 0);
        fs   = ls && (ey == 0);
        tick = en && ((e + 1) % c.div == 0);
        hs   = (ex >= c.ha + c.hf && ex < c.ha + c.hf + c.hs) ? (c.hp != 0) : (c.hp == 0);
        vs   = (ey >= c.va + c.vf && ey < c.va + c.vf + c.vs) ? (c.vp != 0) : (c.vp == 0);
        vo   = (ex < c.ha) && (ey < c.va);
        check_val({tag, "_flags"}, int'(flags), int'({tick, hs, vs, vo, ls, fs}));
        check_val({tag, "_x"}, x, ex);
        check_val({tag, "_y"}, y, ey);
    endtask

    int  hs_run_a = 0, hs_run_c = 0, ticks_b = 0;
    bit  prev_fs_b = 1'b0, seen_fs_b = 1'b0;

    always @(negedge clk) begin
        #1;
        if (run_chk) begin
            cmp_dut("A", cfg_a, e_a, en_a, rst_a, {tick_a, hs_a, vs_a, vo_a, ls_a, fs_a}, int'(x_a), int'(y_a));
            cmp_dut("B", cfg_b, e_b, en_b, rst_b, {tick_b, hs_b, vs_b, vo_b, ls_b, fs_b}, int'(x_b), int'(y_b));
            cmp_dut("C", cfg_c, e_c, en_c, rst_c, {tick_c, hs_c, vs_c, vo_c, ls_c, fs_c}, int'(x_c), int'(y_c));
            if (!hs_a) hs_run_a++;
            else begin
                if (hs_run_a > 0) check_val("A_hsync_low_clks", hs_run_a, 384);
                hs_run_a = 0;
            end
            if (hs_c) hs_run_c++;
            else begin
                if (hs_run_c > 0) check_val("C_hsync_high_clks", hs_run_c, 128);
                hs_run_c = 0;
            end
            if (fs_b && !prev_fs_b) begin
                if (seen_fs_b) check_val("B_frame_tick_spacing", ticks_b, 120);
                seen_fs_b = 1'b1;
                ticks_b   = 0;
            end
            if (tick_b) ticks_b++;
            prev_fs_b = fs_b;
        end
    end

    task automatic fs_latency(input string tag);
        int k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            #1;
            if (fs_a) begin
                k = i;
                break;
            end
        end
        check_val(tag, k, 4);
    endtask

    task automatic seq_a();
        bit hit;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        fs_latency("A_fs_latency_release");
        hit = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            #1;
            if (x_a == 11'd100) begin
                hit = 1'b1;
                break;
            end
        end
        check_val("A_reach_x100", int'(hit), 1);
        @(negedge clk);
        en_a = 1'b0;
        repeat (7) @(negedge clk);
        en_a = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (x_a != 11'd100) begin
                hit = 1'b1;
                break;
            end
        end
        check_val("A_resume_x", hit ? int'(x_a) : -1, 101);
        hit = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            #1;
            if (x_a == 11'd300 && y_a == 11'd1) begin
                hit = 1'b1;
                break;
            end
        end
        check_val("A_reach_x300_y1", int'(hit), 1);
        @(negedge clk);
        rst_a = 1'b1;
        #2;
        check_val("A_async_rst_x", int'(x_a), 799);
        check_val("A_async_rst_y", int'(y_a), 524);
        check_val("A_async_rst_flags", int'({hs_a, vs_a, vo_a, ls_a, fs_a}), 5'b11000);
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        fs_latency("A_fs_latency_after_rst");
        repeat (3500) @(negedge clk);
    endtask

    task automatic seq_b();
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        repeat (2200) begin
            @(negedge clk);
            en_b = ($urandom_range(3) != 0);
        end
        en_b = 1'b1;
    endtask

    task automatic seq_c();
        repeat (3) @(negedge clk);
        rst_c = 1'b0;
        repeat (3500) @(negedge clk);
    endtask

    initial begin
        fork
            seq_a();
            seq_b();
            seq_c();
        join
        @(negedge clk);
        run_chk = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 The block SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 The block SHALL have parameter HS_POL, default 0, hsync level during sync (0 = active-low).
REQ-010 The block SHALL have parameter VS_POL, default 0, vsync level during sync (0 = active-low).
REQ-011 The block SHALL have parameter CLK_DIV, default 4, CLK cycles per pixel, legal range 1..16.
REQ-012 The block SHALL have parameter CW, default 11, coordinate width in bits, wide enough for H_TOTAL-1 and V_TOTAL-1.
REQ-013 CLK  input  1  system clock; all state on rising edge.
REQ-014 RESET  input  1  reset, asynchronous, active-high.
REQ-015 EN  input  1  run enable; low freezes all timing state.
REQ-016 pixel_tick  output  1  one-CLK pixel-enable strobe.
REQ-017 hsync  output  1  horizontal sync, polarity HS_POL.
REQ-018 vsync  output  1  vertical sync, polarity VS_POL.
REQ-019 video_on  output  1  high while (pixel_x, pixel_y) lies in the active area.
REQ-020 line_start  output  1  one-CLK pulse on the first CLK of every line.
REQ-021 frame_start  output  1  one-CLK pulse on the first CLK of every frame.
REQ-022 pixel_x  output  CW  current horizontal count.
REQ-023 pixel_y  output  CW  current vertical count.

Function
REQ-024 The block SHALL use H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; line order is active, front porch, sync, back porch.
REQ-025 A divider SHALL count 0..CLK_DIV-1 while EN=1; pixel_tick = EN AND (div_cnt = CLK_DIV-1); for CLK_DIV=1, pixel_tick = EN.
REQ-026 On each CLK edge with pixel_tick=1: pixel_x SHALL increment, wrapping H_TOTAL-1 -> 0; on that wrap, pixel_y SHALL increment, wrapping V_TOTAL-1 -> 0.
REQ-027 hsync SHALL equal HS_POL when H_ACTIVE+H_FP <= pixel_x <= H_ACTIVE+H_FP+H_SYNC-1, else ~HS_POL; vsync SHALL follow the same rule using the V parameters and VS_POL.
REQ-028 video_on SHALL be high iff pixel_x < H_ACTIVE and pixel_y < V_ACTIVE.
REQ-029 hsync, vsync and video_on SHALL be registered, computed from next-count values, so they are zero-cycle aligned with pixel_x/pixel_y and glitch-free.
REQ-030 line_start SHALL be high exactly for the CLK cycle after a pixel_x wrap; frame_start SHALL be high exactly for the CLK cycle after a simultaneous pixel_x and pixel_y wrap.
REQ-031 With EN=0, the divider, counters and all outputs SHALL hold their values; pixel_tick SHALL be 0; on re-enable, counting resumes with no skipped or repeated pixel.

Reset
REQ-032 On RESET: div_cnt=0, pixel_x=H_TOTAL-1, pixel_y=V_TOTAL-1, hsync=~HS_POL, vsync=~VS_POL, video_on=0, line_start=0, frame_start=0.
REQ-033 The first pixel_tick after RESET release SHALL wrap both counters to (0,0) and raise frame_start and line_start on the following CLK cycle.
REQ-034 RESET asserted mid-frame SHALL immediately (asynchronously) force the REQ-032 values.

Verification
REQ-035 Defaults, EN=1, release RESET -> pixel_x=0, pixel_y=0, video_on=1 and frame_start=1 for one CLK exactly 4 CLKs after release.
REQ-036 Defaults -> hsync low for pixel_x 656..751, i.e. 384 consecutive CLKs per line; vsync low for lines 490..491, i.e. 1600 pixel ticks.
REQ-037 Defaults -> pixel_x wraps 799->0 with pixel_y incrementing; pixel_y wraps 524->0; frame_start is spaced by exactly 420000 pixel ticks.
REQ-038 Drop EN for 7 CLKs mid-line at pixel_x=100 -> all outputs frozen, pixel_tick=0; after re-enable, the next value is pixel_x=101.
REQ-039 Assert RESET at pixel_x=300, pixel_y=200 -> outputs take the REQ-032 values in the same cycle; on release, a new frame starts at (0,0).
REQ-040 CLK_DIV=1, HS_POL=1, VS_POL=1, 800x600 timing (40/128/88, 1/4/23) -> pixel_tick constantly high, hsync high for pixel_x 840..967, H_TOTAL=1056, V_TOTAL=628.
